// File: rtl/priority_grant_arbiter_if.sv
// rtl/priority_grant_arbiter_if.sv - request/grant bundle between requesting engines and the arbiter
interface priority_grant_arbiter_if;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_valid;
    logic       revoke;

    modport master (
        output req,
        output done,
        input  gnt,
        input  gnt_id,
        input  gnt_valid,
        input  revoke
    );

    modport slave (
        input  req,
        input  done,
        output gnt,
        output gnt_id,
        output gnt_valid,
        output revoke
    );
endinterface

// File: rtl/priority_grant_arbiter.sv
// rtl/priority_grant_arbiter.sv - 8-way fixed-priority hold-until-release arbiter; ARB_TIMEOUT_EN adds forced release after MAX_HOLD cycles
module priority_grant_arbiter #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    priority_grant_arbiter_if.slave  bus
);

    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("MAX_HOLD must be within 2..255");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] gnt_q, gnt_d;
    logic [2:0] gnt_id_q, gnt_id_d;
    logic       gnt_valid_q, gnt_valid_d;
    logic [2:0] req_id;
    logic       release_c;

    // Highest set index wins; the ascending loop lets later bits overwrite earlier ones.
    always_comb begin
        req_id = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (bus.req[i]) begin
                req_id = 3'(i);
            end
        end
    end

    assign release_c = bus.done || !bus.req[gnt_id_q];

`ifdef ARB_TIMEOUT_EN
    localparam int HW = $clog2(MAX_HOLD + 1);

    logic [HW-1:0] hold_q, hold_d;
    logic          revoke_q, revoke_d;
`endif

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gnt_id_d    = gnt_id_q;
        gnt_valid_d = gnt_valid_q;
`ifdef ARB_TIMEOUT_EN
        hold_d      = hold_q;
        revoke_d    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                gnt_d       = 8'd0;
                gnt_id_d    = 3'd0;
                gnt_valid_d = 1'b0;
                if (bus.req != 8'd0) begin
                    gnt_d       = 8'b1 << req_id;
                    gnt_id_d    = req_id;
                    gnt_valid_d = 1'b1;
                    state_d     = GRANT;
`ifdef ARB_TIMEOUT_EN
                    hold_d      = '0;
`endif
                end
            end
            GRANT: begin
                if (release_c) begin
                    gnt_d       = 8'd0;
                    gnt_id_d    = 3'd0;
                    gnt_valid_d = 1'b0;
                    state_d     = RELEASE;
                end
`ifdef ARB_TIMEOUT_EN
                // A real release on the same edge takes precedence, so no revoke then.
                else if (hold_q == HW'(MAX_HOLD - 1)) begin
                    gnt_d       = 8'd0;
                    gnt_id_d    = 3'd0;
                    gnt_valid_d = 1'b0;
                    revoke_d    = 1'b1;
                    state_d     = RELEASE;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
`endif
            end
            RELEASE: begin
                gnt_d       = 8'd0;
                gnt_id_d    = 3'd0;
                gnt_valid_d = 1'b0;
                state_d     = IDLE;
            end
            default: begin
                gnt_d       = 8'd0;
                gnt_id_d    = 3'd0;
                gnt_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            gnt_q       <= 8'd0;
            gnt_id_q    <= 3'd0;
            gnt_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            gnt_valid_q <= gnt_valid_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q   <= '0;
            revoke_q <= 1'b0;
        end else begin
            hold_q   <= hold_d;
            revoke_q <= revoke_d;
        end
    end

    assign bus.revoke = revoke_q;
`else
    assign bus.revoke = 1'b0;
`endif

    assign bus.gnt       = gnt_q;
    assign bus.gnt_id    = gnt_id_q;
    assign bus.gnt_valid = gnt_valid_q;

endmodule
